lap_store: RTL and testbench

- Datapath responder to the stopwatch control FSM.
- Watches the FSM's one-hot 11-bit state vector.
  - SAVE: captures lap timestamps into a circular buffer.
  - SAVE / CLEAR: drives LCD write/clear requests to the LCD writer.
  - RESET: wipes the buffer.
- Returns the busy flags that the FSM samples as stimulus[1:0] (lcd_busy, reg_busy).

---
 rtl/lap_store.sv | 143 ++++++++++++++
 tb/tb_lap_store.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/lap_store.sv
// Lap timestamp store for the stopwatch: circular buffer of laps, LCD
// write/clear requests and the busy handshake returned to the control FSM.
module lap_store #(
  parameter int DEPTH  = 8,
  parameter int TIME_W = 24,
  parameter int IDX_W  = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [10:0]       state,
  input  logic [TIME_W-1:0] time_in,
  output logic              lcd_req,
  output logic              lcd_cmd,
  output logic [TIME_W-1:0] lcd_data,
  input  logic              lcd_ack,
  output logic              lcd_busy,
  output logic              reg_busy,
  output logic [IDX_W:0]    lap_count,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [TIME_W-1:0] rd_data
);
  localparam int SAVE  = 6;
  localparam int RESET = 8;
  localparam int CLEAR = 10;
  localparam logic [IDX_W:0]   FULL = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_LCD_WAIT, S_WIPE} seq_t;
  seq_t seq, seq_nxt;

  logic [TIME_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  wr_ptr, wcnt, rd_addr;
  logic [2:0]        prev_state;  // only the watched states need edge detection
  logic legal, lcd_done, wipe_done;
  logic ent_save, ent_clear, ent_reset;
  logic pend_save, pend_clear, pend_reset;
  logic go_save, go_clear, go_reset, wipe_last, ack_seen;

  assign legal     = (state != '0) && ((state & (state - 11'd1)) == '0);
  assign ent_save  = legal & state[SAVE]  & ~prev_state[0];
  assign ent_reset = legal & state[RESET] & ~prev_state[1];
  assign ent_clear = legal & state[CLEAR] & ~prev_state[2];

  assign lcd_busy = legal & (state[SAVE] | state[CLEAR]) & ~lcd_done;
  assign reg_busy = legal & state[RESET] & ~wipe_done;

  assign rd_addr = wr_ptr - rd_idx - 1'b1;
  assign rd_data = ({1'b0, rd_idx} < lap_count) ? mem[rd_addr] : '0;

  always_comb begin
    seq_nxt   = seq;
    go_save   = 1'b0;
    go_clear  = 1'b0;
    go_reset  = 1'b0;
    wipe_last = 1'b0;
    ack_seen  = 1'b0;
    case (seq)
      S_IDLE: begin
        // Fresh entries and ones parked while busy are serviced alike.
        if (ent_reset | pend_reset) begin
          go_reset = 1'b1;
          seq_nxt  = S_WIPE;
        end else if (ent_clear | pend_clear) begin
          go_clear = 1'b1;
          seq_nxt  = S_LCD_WAIT;
        end else if (ent_save | pend_save) begin
          go_save = 1'b1;
          seq_nxt = S_LCD_WAIT;
        end
      end
      S_LCD_WAIT: begin
        if (lcd_ack) begin
          ack_seen = 1'b1;
          seq_nxt  = S_IDLE;
        end
      end
      S_WIPE: begin
        if (wcnt == LAST) begin
          wipe_last = 1'b1;
          seq_nxt   = S_IDLE;
        end
      end
      default: seq_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      seq        <= S_IDLE;
      prev_state <= '0;
      wr_ptr     <= '0;
      wcnt       <= '0;
      lap_count  <= '0;
      lcd_req    <= 1'b0;
      lcd_cmd    <= 1'b0;
      lcd_data   <= '0;
      lcd_done   <= 1'b0;
      wipe_done  <= 1'b0;
      pend_save  <= 1'b0;
      pend_clear <= 1'b0;
      pend_reset <= 1'b0;
    end else begin
      seq        <= seq_nxt;
      prev_state <= {state[CLEAR], state[RESET], state[SAVE]};
      pend_save  <= (pend_save  | ent_save)  & ~go_save;
      pend_clear <= (pend_clear | ent_clear) & ~go_clear;
      pend_reset <= (pend_reset | ent_reset) & ~go_reset;

      if (go_save) begin
        wr_ptr   <= wr_ptr + 1'b1;
        lcd_data <= time_in;
        lcd_cmd  <= 1'b0;
        lcd_req  <= 1'b1;
        if (lap_count != FULL) lap_count <= lap_count + 1'b1;
      end
      if (go_clear) begin
        lcd_cmd <= 1'b1;
        lcd_req <= 1'b1;
      end
      if (ack_seen) lcd_req <= 1'b0;

      if (go_reset)           wcnt <= '0;
      else if (seq == S_WIPE) wcnt <= wcnt + 1'b1;
      if (wipe_last) begin
        wr_ptr    <= '0;
        lap_count <= '0;
      end

      // Done flags only live while the FSM sits in the matching state.
      if (!(state[SAVE] | state[CLEAR])) lcd_done <= 1'b0;
      else if (ack_seen)                 lcd_done <= 1'b1;
      if (!state[RESET])  wipe_done <= 1'b0;
      else if (wipe_last) wipe_done <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset_n) begin
      if (go_save)            mem[wr_ptr] <= time_in;
      else if (seq == S_WIPE) mem[wcnt]   <= '0;
    end
  end
endmodule

// File: tb/tb_lap_store.sv
// Self-checking bench for lap_store: directed corner sequences, small vector
// tables and a randomized lap/wipe mix against a queue model of the laps.
module tb_lap_store;
  localparam int DEPTH = 8, TIME_W = 24, IDX_W = 3;
  localparam logic [10:0] IDLE = 11'h001, RUN = 11'h004, PAUSE = 11'h010,
                          SAVE = 11'h040, PRE_RESET = 11'h080, RESET = 11'h100,
                          PRE_CLEAR = 11'h200, CLEAR = 11'h400;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [10:0]       state = IDLE;
  logic [TIME_W-1:0] time_in = '0;
  logic              lcd_req, lcd_cmd, lcd_ack = 1'b0, lcd_busy, reg_busy;
  logic [TIME_W-1:0] lcd_data, rd_data;
  logic [IDX_W:0]    lap_count;
  logic [IDX_W-1:0]  rd_idx = '0;

  int checks = 0, failures = 0;
  logic [TIME_W-1:0] laps[$];  // most recent first

  typedef struct { logic [10:0] st; logic lb; logic rb; } st_vec_t;
  typedef struct { logic [IDX_W-1:0] idx; logic [TIME_W-1:0] exp; } rd_vec_t;
  st_vec_t svec[6];
  rd_vec_t rvec[8];

  lap_store #(.DEPTH(DEPTH), .TIME_W(TIME_W), .IDX_W(IDX_W)) dut (
    .clock(clock), .reset_n(reset_n), .state(state), .time_in(time_in),
    .lcd_req(lcd_req), .lcd_cmd(lcd_cmd), .lcd_data(lcd_data), .lcd_ack(lcd_ack),
    .lcd_busy(lcd_busy), .reg_busy(reg_busy), .lap_count(lap_count),
    .rd_idx(rd_idx), .rd_data(rd_data));

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  function automatic logic [TIME_W-1:0] exp_rd(input int idx);
    return (idx < laps.size()) ? laps[idx] : '0;
  endfunction

  task automatic model_save(input logic [TIME_W-1:0] t);
    laps.push_front(t);
    if (laps.size() > DEPTH) void'(laps.pop_back());
  endtask

  task automatic check_reads();
    for (int i = 0; i < DEPTH; i++) begin
      rd_idx = IDX_W'(i); #1;
      chk("rd_data", rd_data, exp_rd(i));
      @(posedge clock); #1;
    end
    chk("lap_count", lap_count, laps.size());
  endtask

  // FSM enters SAVE from RUN; bench acts as LCD writer acking after dly cycles.
  task automatic save_lap(input logic [TIME_W-1:0] t, input int dly);
    state = SAVE; time_in = t; #1;
    chk("save_busy_entry", lcd_busy, 1);
    @(posedge clock); #1;
    model_save(t);
    chk("save_req", lcd_req, 1);
    chk("save_cmd", lcd_cmd, 0);
    chk("save_data", lcd_data, t);
    chk("save_count", lap_count, laps.size());
    for (int i = 0; i < dly; i++) begin
      chk("save_req_hold", lcd_req, 1);
      chk("save_busy_hold", lcd_busy, 1);
      step();
    end
    lcd_ack = 1'b1; #1;
    chk("save_busy_ack", lcd_busy, 1);
    @(posedge clock); #1;
    lcd_ack = 1'b0;
    chk("save_req_done", lcd_req, 0);
    chk("save_busy_done", lcd_busy, 0);
    state = RUN; step();
  endtask

  task automatic wipe();
    int cnt;
    cnt = 0;
    state = PAUSE; step();
    state = PRE_RESET; step();
    state = RESET;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!reg_busy) break;
      cnt++;
      @(posedge clock); #1;
    end
    @(posedge clock); #1;
    laps.delete();
    chk("wipe_busy_cycles", cnt, DEPTH + 1);
    chk("wipe_count", lap_count, 0);
    state = IDLE; step();
    check_reads();
  endtask

  initial begin
    svec[0] = '{11'h000, 1'b0, 1'b0};
    svec[1] = '{11'h041, 1'b0, 1'b0};
    svec[2] = '{11'h140, 1'b0, 1'b0};
    svec[3] = '{11'h440, 1'b0, 1'b0};
    svec[4] = '{11'h7FF, 1'b0, 1'b0};
    svec[5] = '{PAUSE,   1'b0, 1'b0};
    for (int i = 0; i < 8; i++) rvec[i] = '{IDX_W'(i), TIME_W'(9 - i)};

    // Reset
    repeat (2) @(posedge clock);
    #1;
    chk("rst_req", lcd_req, 0);
    chk("rst_cmd", lcd_cmd, 0);
    chk("rst_data", lcd_data, 0);
    chk("rst_count", lap_count, 0);
    reset_n = 1'b1;
    state = RUN; step();

    // 1: single lap
    save_lap(24'h012345, 3);
    rd_idx = '0; #1;
    chk("t1_rd0", rd_data, 24'h012345);
    step();

    // 2: wrap-around
    for (int i = 1; i <= 9; i++) save_lap(TIME_W'(i), i % 3);
    chk("t2_count", lap_count, DEPTH);
    foreach (rvec[i]) begin
      rd_idx = rvec[i].idx; #1;
      chk("t2_rd", rd_data, rvec[i].exp);
      step();
    end

    // 3: wipe after 5 laps
    reset_n = 1'b0; step(); reset_n = 1'b1;
    laps.delete();
    state = RUN; step();
    for (int i = 0; i < 5; i++) save_lap(TIME_W'(24'h000100 + i), 1);
    check_reads();
    wipe();

    // 4: clear with stray ack and long ack delay
    state = PRE_CLEAR; lcd_ack = 1'b1; step();
    lcd_ack = 1'b0;
    chk("t4_stray_req", lcd_req, 0);
    chk("t4_stray_busy", lcd_busy, 0);
    state = CLEAR; #1;
    chk("t4_busy_entry", lcd_busy, 1);
    @(posedge clock); #1;
    chk("t4_req", lcd_req, 1);
    chk("t4_cmd", lcd_cmd, 1);
    for (int i = 0; i < 10; i++) begin
      chk("t4_req_hold", lcd_req, 1);
      chk("t4_busy_hold", lcd_busy, 1);
      step();
    end
    lcd_ack = 1'b1; #1;
    chk("t4_req_ack", lcd_req, 1);
    chk("t4_busy_ack", lcd_busy, 1);
    @(posedge clock); #1;
    lcd_ack = 1'b0;
    chk("t4_req_done", lcd_req, 0);
    chk("t4_busy_done", lcd_busy, 0);
    state = IDLE; step();

    // 5a: reset during wipe
    state = RUN; step();
    save_lap(24'h111111, 0);
    save_lap(24'h222222, 2);
    state = PAUSE; step();
    state = PRE_RESET; step();
    state = RESET; step(); step(); step();
    chk("t5_wipe_busy", reg_busy, 1);
    chk("t5_wipe_count", lap_count, 2);
    reset_n = 1'b0; state = IDLE; step();
    laps.delete();
    chk("t5a_req", lcd_req, 0);
    chk("t5a_cmd", lcd_cmd, 0);
    chk("t5a_data", lcd_data, 0);
    chk("t5a_count", lap_count, 0);
    reset_n = 1'b1; step();

    // 5b: reset during LCD wait, late ack ignored
    state = RUN; step();
    state = SAVE; time_in = 24'hABCDEF; step();
    chk("t5b_req_pre", lcd_req, 1);
    reset_n = 1'b0; state = IDLE; step();
    chk("t5b_req", lcd_req, 0);
    chk("t5b_cmd", lcd_cmd, 0);
    chk("t5b_data", lcd_data, 0);
    chk("t5b_count", lap_count, 0);
    reset_n = 1'b1; step();
    lcd_ack = 1'b1; step(); lcd_ack = 1'b0;
    chk("t5b_req_after_ack", lcd_req, 0);
    check_reads();

    // 6: illegal state vectors
    state = RUN; step();
    save_lap(24'h333333, 1);
    foreach (svec[i]) begin
      state = svec[i].st; #1;
      chk("t6_lcd_busy", lcd_busy, svec[i].lb);
      chk("t6_reg_busy", reg_busy, svec[i].rb);
      @(posedge clock); #1;
      chk("t6_req", lcd_req, 0);
      chk("t6_count", lap_count, laps.size());
    end
    state = RUN; step(); step();

    // Random laps and wipes vs queue model
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        wipe();
        state = RUN; step();
      end else begin
        save_lap(TIME_W'($urandom), int'($urandom_range(0, 3)));
      end
      rd_idx = IDX_W'($urandom_range(0, DEPTH - 1)); #1;
      chk("rand_rd", rd_data, exp_rd(int'(rd_idx)));
      chk("rand_count", lap_count, laps.size());
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
